// File: rtl/row_fetch_if.sv
// Row fetch bus: controller handshake, frame BRAM read port and line-buffer
// write port of the row fetch unit, grouped so they travel as one port.
interface row_fetch_if #(
    parameter int MAX_ROW = 480,
    parameter int MAX_COL = 640,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 19
);
    localparam int ROW_W = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
    localparam int COL_W = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;

    // controller handshake
    logic              fetch_req_i;
    logic              frame_clr_i;
    logic              fetch_done_o;
    logic              busy_o;
    logic              last_row_o;
    logic [ROW_W-1:0]  row_idx_o;
    // frame BRAM read port
    logic              bram_en_o;
    logic [ADDR_W-1:0] bram_addr_o;
    logic [DATA_W-1:0] bram_rdata_i;
    // line-buffer write port
    logic              buf_we_o;
    logic [1:0]        buf_sel_o;
    logic [COL_W-1:0]  buf_waddr_o;
    logic [DATA_W-1:0] buf_wdata_o;

    // the fetch unit itself
    modport slave (
        input  fetch_req_i, frame_clr_i, bram_rdata_i,
        output fetch_done_o, busy_o, last_row_o, row_idx_o,
               bram_en_o, bram_addr_o, buf_we_o, buf_sel_o, buf_waddr_o, buf_wdata_o
    );

    // controller plus BRAM/line-buffer environment
    modport master (
        output fetch_req_i, frame_clr_i, bram_rdata_i,
        input  fetch_done_o, busy_o, last_row_o, row_idx_o,
               bram_en_o, bram_addr_o, buf_we_o, buf_sel_o, buf_waddr_o, buf_wdata_o
    );
endinterface

// File: rtl/row_fetch_unit.sv
// Row fetch unit: on request, streams one image row out of frame BRAM into
// line-buffer slot (row mod 3), pulses fetch_done and advances the row pointer.
module row_fetch_unit #(
    parameter int MAX_ROW = 480,
    parameter int MAX_COL = 640,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 19,
    parameter int RD_LAT  = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    row_fetch_if.slave bus
);
    localparam int ROW_W = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
    localparam int COL_W = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [COL_W-1:0]  col_q;
    logic [1:0]        slot_q;
    logic              en_q;
    logic              done_q;
    logic              last_q;
    logic              busy_q;

    // read-return pipe: valid + column, RD_LAT deep, aligned with BRAM data
    logic [RD_LAT-1:0] vld_q;
    logic [COL_W-1:0]  pcol_q [RD_LAT];
    logic              pipe_empty_next_s;

    // Pipe will hold no valid read after the coming edge (no new issue, no
    // valid in any stage that shifts forward).
    always_comb begin
        pipe_empty_next_s = ~en_q;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pipe_empty_next_s = pipe_empty_next_s & ~vld_q[i];
        end
    end

    // Shift register carrying issued reads until their data returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pcol_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= en_q;
            pcol_q[0] <= col_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                pcol_q[i] <= pcol_q[i-1];
            end
        end
    end

    // Control FSM with row/base/slot tracking and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            col_q   <= '0;
            slot_q  <= 2'd0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            last_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // a frame clear wins over a simultaneous fetch request
                    if (bus.frame_clr_i) begin
                        row_q  <= '0;
                        base_q <= '0;
                        slot_q <= 2'd0;
                    end else if (bus.fetch_req_i) begin
                        state_q <= S_READ;
                        busy_q  <= 1'b1;
                        en_q    <= 1'b1;
                        addr_q  <= base_q;
                        col_q   <= '0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_READ: begin
                    if (col_q == COL_W'(MAX_COL - 1)) begin
                        state_q <= S_DRAIN;
                        en_q    <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        col_q  <= col_q + COL_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty_next_s) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        last_q  <= (row_q == ROW_W'(MAX_ROW - 1));
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (row_q == ROW_W'(MAX_ROW - 1)) begin
                        row_q  <= '0;
                        base_q <= '0;
                        slot_q <= 2'd0;
                    end else begin
                        row_q  <= row_q + ROW_W'(1);
                        base_q <= base_q + ADDR_W'(MAX_COL);
                        slot_q <= (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_done_o = done_q;
    assign bus.busy_o       = busy_q;
    assign bus.last_row_o   = last_q;
    assign bus.row_idx_o    = row_q;
    assign bus.bram_en_o    = en_q;
    assign bus.bram_addr_o  = addr_q;
    assign bus.buf_we_o     = vld_q[RD_LAT-1];
    assign bus.buf_sel_o    = slot_q;
    assign bus.buf_waddr_o  = pcol_q[RD_LAT-1];
    // BRAM data passes straight through; gated so the bus reads 0 when idle
    assign bus.buf_wdata_o  = vld_q[RD_LAT-1] ? bus.bram_rdata_i : '0;
endmodule

// File: tb/tb_row_fetch_unit.sv
// Directed bench for row_fetch_unit: two instances (RD_LAT 1 and 2) on small
// frames; line-buffer writes are checked against a queue filled at request time.
module tb_row_fetch_unit;
    localparam int MAX_ROW = 3;
    localparam int MAX_COL = 4;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 19;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic req   = 1'b0;
    logic clr   = 1'b0;
    logic dsel  = 1'b0;   // 0: RD_LAT=1 instance, 1: RD_LAT=2 instance

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] q1 [$];
    logic [23:0] q2 [$];
    logic [23:0] ent1, ent2;

    always #5 clk = ~clk;

    row_fetch_if #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
    row_fetch_if #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

    row_fetch_unit #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    row_fetch_unit #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    assign bus1.fetch_req_i = req & ~dsel;
    assign bus1.frame_clr_i = clr & ~dsel;
    assign bus2.fetch_req_i = req & dsel;
    assign bus2.frame_clr_i = clr & dsel;

    // BRAM models, mem[a] = a
    logic [7:0] rd1_q  = 8'd0;
    logic [7:0] rd2a_q = 8'd0;
    logic [7:0] rd2b_q = 8'd0;
    always @(posedge clk) begin
        if (bus1.bram_en_o) rd1_q <= bus1.bram_addr_o[7:0];
        if (bus2.bram_en_o) rd2a_q <= bus2.bram_addr_o[7:0];
        rd2b_q <= rd2a_q;
    end
    assign bus1.bram_rdata_i = rd1_q;
    assign bus2.bram_rdata_i = rd2b_q;

    // observed outputs of the currently selected instance
    logic        o_en, o_we, o_done, o_last, o_busy;
    logic [18:0] o_addr;
    logic [1:0]  o_sel, o_row, o_waddr;
    logic [7:0]  o_wdata;
    always_comb begin
        if (dsel) begin
            o_en = bus2.bram_en_o; o_we = bus2.buf_we_o; o_done = bus2.fetch_done_o;
            o_last = bus2.last_row_o; o_busy = bus2.busy_o; o_addr = bus2.bram_addr_o;
            o_sel = bus2.buf_sel_o; o_row = bus2.row_idx_o; o_waddr = bus2.buf_waddr_o;
            o_wdata = bus2.buf_wdata_o;
        end else begin
            o_en = bus1.bram_en_o; o_we = bus1.buf_we_o; o_done = bus1.fetch_done_o;
            o_last = bus1.last_row_o; o_busy = bus1.busy_o; o_addr = bus1.bram_addr_o;
            o_sel = bus1.buf_sel_o; o_row = bus1.row_idx_o; o_waddr = bus1.buf_waddr_o;
            o_wdata = bus1.buf_wdata_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitors: every line-buffer write must match the next expected entry
    always @(negedge clk) begin
        if (bus1.buf_we_o === 1'b1 && q1.size() > 0) begin
            ent1 = q1.pop_front();
            chk("sb1_sel",   bus1.buf_sel_o,   ent1[23:16]);
            chk("sb1_waddr", bus1.buf_waddr_o, ent1[15:8]);
            chk("sb1_wdata", bus1.buf_wdata_o, ent1[7:0]);
        end else if (bus1.buf_we_o !== 1'b0) begin
            chk("sb1_spurious_we", bus1.buf_we_o, 32'd0);
        end
    end
    always @(negedge clk) begin
        if (bus2.buf_we_o === 1'b1 && q2.size() > 0) begin
            ent2 = q2.pop_front();
            chk("sb2_sel",   bus2.buf_sel_o,   ent2[23:16]);
            chk("sb2_waddr", bus2.buf_waddr_o, ent2[15:8]);
            chk("sb2_wdata", bus2.buf_wdata_o, ent2[7:0]);
        end else if (bus2.buf_we_o !== 1'b0) begin
            chk("sb2_spurious_we", bus2.buf_we_o, 32'd0);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_done"},  o_done,  32'd0);
        chk({tag, "_busy"},  o_busy,  32'd0);
        chk({tag, "_last"},  o_last,  32'd0);
        chk({tag, "_row"},   o_row,   32'd0);
        chk({tag, "_en"},    o_en,    32'd0);
        chk({tag, "_addr"},  o_addr,  32'd0);
        chk({tag, "_we"},    o_we,    32'd0);
        chk({tag, "_sel"},   o_sel,   32'd0);
        chk({tag, "_waddr"}, o_waddr, 32'd0);
        chk({tag, "_wdata"}, o_wdata, 32'd0);
    endtask

    // one full row fetch with cycle-exact checks; noisy toggles req/clr while busy
    task automatic run_row(input int base, input int sel, input bit last, input int nrow, input bit noisy);
        int lat;
        int n_cyc;
        lat   = dsel ? 2 : 1;
        n_cyc = MAX_COL + lat + 1;
        for (int c = 0; c < MAX_COL; c++) begin
            if (dsel) q2.push_back({8'(sel), 8'(c), 8'(base + c)});
            else      q1.push_back({8'(sel), 8'(c), 8'(base + c)});
        end
        @(negedge clk);
        req = 1'b1;
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge clk);
            req = (noisy && k < n_cyc) ? k[0]  : 1'b0;
            clr = (noisy && k < n_cyc) ? ~k[0] : 1'b0;
            chk("row_en", o_en, 32'(k <= MAX_COL));
            if (k <= MAX_COL) chk("row_addr", o_addr, 32'(base + k - 1));
            chk("row_we",   o_we,   32'(k > lat && k <= MAX_COL + lat));
            chk("row_done", o_done, 32'(k == n_cyc));
            chk("row_last", o_last, 32'(k == n_cyc && last));
            chk("row_busy", o_busy, 32'd1);
        end
        @(negedge clk);
        chk("after_busy", o_busy, 32'd0);
        chk("after_done", o_done, 32'd0);
        chk("after_row",  o_row,  32'(nrow));
    endtask

    initial begin
        // reset state of both instances
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst1");
        dsel = 1'b1;
        check_zero("rst2");
        dsel = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // single request, then rows 1 and 2 back to back (last row flagged, wrap)
        run_row(0, 0, 1'b0, 1, 1'b0);
        run_row(4, 1, 1'b0, 2, 1'b0);
        run_row(8, 2, 1'b1, 0, 1'b0);
        // after the frame wrap: slot 0, base 0
        run_row(0, 0, 1'b0, 1, 1'b0);
        // req/clr pulses while busy are ignored
        run_row(4, 1, 1'b0, 2, 1'b1);

        // clear and request together in idle at row 2: clear wins, no fetch
        @(negedge clk);
        req = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        req = 1'b0;
        clr = 1'b0;
        chk("clr_row",  o_row,  32'd0);
        chk("clr_busy", o_busy, 32'd0);
        chk("clr_en",   o_en,   32'd0);
        @(negedge clk);
        chk("clr_busy2", o_busy, 32'd0);
        chk("clr_en2",   o_en,   32'd0);
        run_row(0, 0, 1'b0, 1, 1'b0);

        // reset in the middle of a row (row 1): abort, no done, back to row 0
        q1.push_back({8'd1, 8'd0, 8'd4});
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("mid_en", o_en, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_rst");
        rst_n = 1'b1;
        q1.delete();
        repeat (3) begin
            @(negedge clk);
            chk("mid_nodone", o_done, 32'd0);
        end
        run_row(0, 0, 1'b0, 1, 1'b0);

        // two-cycle BRAM latency instance
        dsel = 1'b1;
        run_row(0, 0, 1'b0, 1, 1'b0);
        dsel = 1'b0;

        repeat (2) @(negedge clk);
        chk("sb1_empty", q1.size(), 32'd0);
        chk("sb2_empty", q2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
